multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits, minimum 8.
REQ-003 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; sampled on the rising edge.
- type_code  input  2  00 = arithmetic/logic; other values = address pass-through.
- op_code  input  4  operation select.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- busy  output  1  MUL/DIV in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  signed result, registered.
- negative  output  1  result MSB.
- zero  output  1  result == 0.
- carry  output  1  ADD carry-out / SUB no-borrow.
- overflow  output  1  signed overflow.
- div_by_zero  output  1  DIV with b == 0.

Function
REQ-004 start SHALL be accepted only in a cycle where busy=0; a, b, type_code and op_code SHALL be captured at acceptance.
- Inputs SHALL NOT be sampled again until the next acceptance.
- start while busy=1 SHALL be ignored, with no queueing.
REQ-005 With type_code=00, op_code SHALL select the operation:
- 0000: ADD, a+b.
- 0001: SUB, a-b.
- 0010: MUL, low WIDTH bits of the signed product.
- 0011: DIV, signed quotient truncated toward zero.
- 0100: AND.
- 0101: OR.
- 0110: XOR.
- 0111: NEG, two's-complement -a.
- 1000: MOV, b.
- 1001-1111: result 0.
REQ-006 With type_code != 00, result SHALL be b regardless of op_code, as a single-cycle operation.
REQ-007 Single-cycle operations are all except MUL and DIV. If accepted at edge k, result, flags and done=1 SHALL be valid in cycle k+1; busy SHALL stay 0.
REQ-008 MUL SHALL be an iterative shift-add of |a|·|b| with sign correction.
- busy=1 in cycles k+1..k+WIDTH.
- done=1 with valid result in cycle k+WIDTH+1; busy=0 in that cycle.
REQ-009 DIV SHALL be an iterative restoring divide of |a|/|b| with sign correction, with the same timing as MUL.
REQ-010 DIV with b=0 SHALL complete as a single-cycle operation: result=0, div_by_zero=1, overflow=0.
REQ-011 DIV with a=-2^(WIDTH-1) and b=-1 SHALL give result=-2^(WIDTH-1) and overflow=1, with normal multi-cycle timing.
REQ-012 The state machine SHALL have three states:
- IDLE.
- ITER, with an iteration counter 0..WIDTH-1.
- FINISH.
Transitions:
- IDLE to ITER on accepted MUL/DIV (except b=0 DIV).
- ITER to FINISH when the counter reaches WIDTH-1.
- FINISH to IDLE unconditionally.
- A single-cycle operation SHALL be completed from IDLE or FINISH directly.
REQ-013 Acceptance SHALL be permitted in the FINISH cycle (done=1, busy=0), giving back-to-back operations.
REQ-014 done SHALL be high for exactly one cycle per accepted operation and SHALL be low otherwise.
REQ-015 result and all flags SHALL update only in the done cycle and SHALL hold their values until the next done.
REQ-016 Flags SHALL be computed from the final result:
- negative = result[WIDTH-1].
- zero = (result==0).
- carry:
  - ADD: carry-out of the unsigned sum.
  - SUB: 1 when a>=b unsigned.
  - All other operations: 0.
- overflow:
  - ADD/SUB: signed overflow.
  - NEG: a=-2^(WIDTH-1).
  - MUL: the full 2·WIDTH signed product is not representable in WIDTH bits.
  - DIV: per REQ-011.
  - All other operations: 0.
- div_by_zero = 0 except per REQ-010.

Reset
REQ-017 When reset=1 at a clock edge, the block SHALL:
- set state to IDLE and the counter to 0;
- set busy, done, result, negative, zero, carry, overflow and div_by_zero to 0.
REQ-018 reset SHALL take priority over start. Reset during ITER SHALL abandon the operation, with no done pulse for it.

Verification
REQ-019 ADD: a=0x7FFFFFFF, b=1, accepted at cycle 0 -> cycle 1: done=1, result=0x80000000, N=1, Z=0, C=0, V=1, busy=0.
REQ-020 SUB: a=5, b=5 -> result=0, Z=1, C=1, V=0. Back-to-back XOR (0xF0F0F0F0 ^ 0xFFFFFFFF) accepted in the next cycle -> result=0x0F0F0F0F, done in consecutive cycles.
REQ-021 MUL: a=-3, b=7 at cycle 0 -> busy=1 in cycles 1..32; a start in cycle 5 is ignored; cycle 33: done=1, result=0xFFFFFFEB, N=1, V=0. MUL 0x10000 × 0x10000 -> result 0, Z=1, V=1.
REQ-022 DIV: -7/2 -> result=-3 (0xFFFFFFFD) at cycle 33. DIV 5/0 -> cycle 1: result=0, div_by_zero=1. DIV 0x80000000/-1 -> result=0x80000000, V=1.
REQ-023 Reset: reset=1 in cycle 10 of a DIV -> cycle 11: busy=0, result=0, all flags 0; no done through cycle 40; a new ADD 2+3 then gives done=1, result=5 one cycle after acceptance.
REQ-024 Pass-through: type_code=01, op_code=0001, a=9, b=0x1000 -> cycle 1: result=0x1000, Z=0, C=0, V=0.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle add/sub/logic/move/pass-through plus iterative
// shift-add multiply and restoring divide sharing one hi/lo register pair.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       type_code,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             neg_q, neg_d, div_q, div_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m, input logic neg);
    return neg ? -m : m;
  endfunction

  logic [WIDTH:0]   add_w, sub_w, mul_sum, div_trial;
  logic [WIDTH-1:0] sc_res, step_hi, step_lo, div_quo;
  logic [2*WIDTH-1:0] mul_full;
  logic             sc_c, sc_v, sc_dbz, mul_ovf, div_ovf;
  logic             accept, iter_op, a_min;

  assign add_w     = {1'b0, a} + {1'b0, b};
  assign sub_w     = {1'b0, a} - {1'b0, b};
  assign a_min     = (a == {1'b1, {(WIDTH-1){1'b0}}});
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dbz = 1'b0;
    if (type_code != 2'b00) begin
      sc_res = b;
    end else begin
      case (op_code)
        4'h0: begin
          sc_res = add_w[WIDTH-1:0];
          sc_c   = add_w[WIDTH];
          sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
        end
        4'h1: begin
          sc_res = sub_w[WIDTH-1:0];
          sc_c   = ~sub_w[WIDTH];
          sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
        end
        // Only the b == 0 divide is completed here; other divides iterate.
        4'h3: sc_dbz = 1'b1;
        4'h4: sc_res = a & b;
        4'h5: sc_res = a | b;
        4'h6: sc_res = a ^ b;
        4'h7: begin
          sc_res = -a;
          sc_v   = a_min;
        end
        4'h8: sc_res = b;
        default: sc_res = '0;
      endcase
    end
  end

  // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  // Multiply: hi = running sum, lo = multiplier shifting out / product low half in.
  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  assign mul_full = apply_sign({step_hi, step_lo}, neg_q);
  assign mul_ovf  = !((&mul_full[2*WIDTH-1:WIDTH-1]) || !(|mul_full[2*WIDTH-1:WIDTH-1]));
  assign div_quo  = neg_q ? -step_lo : step_lo;
  // A positive quotient with the MSB set can only be MIN / -1.
  assign div_ovf  = !neg_q && step_lo[WIDTH-1];

  assign accept  = start && (state_q != ITER);
  assign iter_op = (type_code == 2'b00) &&
                   ((op_code == 4'h2) || ((op_code == 4'h3) && (b != '0)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    div_d    = div_q;
    done_d   = 1'b0;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    dbz_d    = dbz_q;
    case (state_q)
      ITER: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = FINISH;
          cnt_d    = '0;
          done_d   = 1'b1;
          result_d = div_q ? div_quo : mul_full[WIDTH-1:0];
          c_d      = 1'b0;
          v_d      = div_q ? div_ovf : mul_ovf;
          dbz_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (iter_op) begin
            state_d = ITER;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = magnitude(a);
            opnd_d  = magnitude(b);
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            div_d   = op_code[0];
          end else begin
            done_d   = 1'b1;
            result_d = sc_res;
            c_d      = sc_c;
            v_d      = sc_v;
            dbz_d    = sc_dbz;
          end
        end
      end
    endcase
    if (done_d) begin
      n_d = result_d[WIDTH-1];
      z_d = (result_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      dbz_q    <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
    neg_q  <= neg_d;
    div_q  <= div_d;
  end

  assign busy        = (state_q == ITER);
  assign done        = done_q;
  assign result      = result_q;
  assign negative    = n_q;
  assign zero        = z_q;
  assign carry       = c_q;
  assign overflow    = v_q;
  assign div_by_zero = dbz_q;

endmodule
